ddr3_axi_traffic_gen: RTL and testbench

AXI4 master traffic generator and checker that sits directly upstream of `ddr3_top_axi` on the controller-clock domain.
- On a start pulse it writes NUM_BURSTS INCR bursts of address-derived data, then reads every burst back.
- Each read beat is compared against the expected pattern, and responses are checked.
- Pass/fail and an error count are reported for board bring-up and regression benches.

---
 rtl/ddr3_axi_tg_pkg.sv | 24 ++
 rtl/ddr3_axi_traffic_gen.sv | 199 +++++++++++++++++++
 tb/tb_ddr3_axi_traffic_gen.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_axi_tg_pkg.sv
// Shared types and helpers for the DDR3 AXI traffic generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ddr3_axi_tg_pkg;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } tg_state_t;

  // One 32-bit word of the test pattern for a given beat byte address.
  function automatic logic [31:0] tg_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ddr3_axi_traffic_gen.sv
// AXI4 write-then-readback traffic generator/checker with pass/fail and error count.
// Latency: awvalid/o_busy rise on the edge sampling i_start; results valid the edge after the last R beat.
// Backpressure: one transaction outstanding; every valid holds until ready; watchdog aborts a stalled pass.
module ddr3_axi_traffic_gen
  import ddr3_axi_tg_pkg::*;
#(
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        BURST_LEN      = 4,
  parameter int                        NUM_BURSTS     = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]               SEED           = 32'hA5A5_0000,
  parameter logic [AXI_ID_WIDTH-1:0]   TG_ID          = '0,
  parameter int                        TIMEOUT        = 4096
) (
  input  logic                          i_controller_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic                          o_timeout,
  output logic [15:0]                   o_error_count,
  // AW channel
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  // W channel
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  // B channel
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  // AR channel
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  // R channel
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic [1:0]                    m_axi_rresp
);

  localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int WORDS       = AXI_DATA_WIDTH / 32;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int WD_W        = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [WD_W-1:0]    WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]         AXI_SIZE   = 3'($clog2(BEAT_BYTES));
  localparam logic [7:0]         AXI_LEN    = 8'(BURST_LEN - 1);

  tg_state_t            state, state_next;
  logic [BEAT_W-1:0]    beat;
  logic [BURST_W-1:0]   burst;
  logic [WD_W-1:0]      wd_cnt;
  logic [15:0]          err_cnt;
  logic                 timeout_flag;

  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic                 busy, start_ok, last_beat, last_burst, wd_expired;
  logic                 b_bad, r_bad;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr, beat_addr;
  logic [31:0]          pat_word;
  logic [AXI_DATA_WIDTH-1:0] pat_beat;

  // Channel valids/readies are pure state decodes, so reset drops them asynchronously.
  assign m_axi_awvalid = (state == WR_ADDR);
  assign m_axi_wvalid  = (state == WR_DATA);
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_ADDR);
  assign m_axi_rready  = (state == RD_DATA);

  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid  & m_axi_wready;
  assign b_hs   = m_axi_bvalid  & m_axi_bready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid  & m_axi_rready;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign busy       = (state != IDLE) && (state != DONE);
  assign start_ok   = i_start && !busy;
  assign last_beat  = (beat == LAST_BEAT);
  assign last_burst = (burst == LAST_BURST);
  assign wd_expired = busy && (wd_cnt == WD_LIMIT) && !any_hs;

  // Address and expected-data generation from the burst/beat counters.
  assign burst_addr = BASE_ADDR + AXI_ADDR_WIDTH'(burst) * AXI_ADDR_WIDTH'(BURST_BYTES);
  assign beat_addr  = burst_addr + AXI_ADDR_WIDTH'(beat) * AXI_ADDR_WIDTH'(BEAT_BYTES);
  assign pat_word   = tg_pattern(32'(beat_addr), SEED);
  assign pat_beat   = {WORDS{pat_word}};

  // Payloads read as zero whenever their valid is low (including during reset).
  assign m_axi_awid    = TG_ID;
  assign m_axi_awaddr  = m_axi_awvalid ? burst_addr : '0;
  assign m_axi_awlen   = AXI_LEN;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = m_axi_wvalid ? pat_beat : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = m_axi_wvalid & last_beat;
  assign m_axi_arid    = TG_ID;
  assign m_axi_araddr  = m_axi_arvalid ? burst_addr : '0;
  assign m_axi_arlen   = AXI_LEN;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = AXI_BURST_INCR;

  // Response checks; beat position, not rlast, decides where a burst ends.
  assign b_bad = (m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != TG_ID);
  assign r_bad = (m_axi_rdata != pat_beat) || (m_axi_rresp != AXI_RESP_OKAY) ||
                 (m_axi_rid != TG_ID) || (m_axi_rlast != last_beat);

  assign o_busy        = busy;
  assign o_done        = (state == DONE);
  assign o_pass        = o_done && (err_cnt == 16'd0) && !timeout_flag;
  assign o_timeout     = timeout_flag;
  assign o_error_count = err_cnt;

  // State register.
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: write all bursts, read them all back; watchdog overrides to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (i_start) state_next = WR_ADDR;
      WR_ADDR:    if (aw_hs) state_next = WR_DATA;
      WR_DATA:    if (w_hs && last_beat) state_next = WR_RESP;
      WR_RESP:    if (b_hs) state_next = last_burst ? RD_ADDR : WR_ADDR;
      RD_ADDR:    if (ar_hs) state_next = RD_DATA;
      RD_DATA:    if (r_hs && last_beat) state_next = last_burst ? DONE : RD_ADDR;
      default:    state_next = IDLE;
    endcase
    if (wd_expired) state_next = DONE;
  end

  // Beat and burst counters; burst wraps to 0 between the write and read phases.
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      beat  <= '0;
      burst <= '0;
    end else if (start_ok) begin
      beat  <= '0;
      burst <= '0;
    end else begin
      if (aw_hs || ar_hs)     beat <= '0;
      else if (w_hs || r_hs)  beat <= last_beat ? '0 : beat + BEAT_W'(1);
      if (b_hs)                                   burst <= last_burst ? '0 : burst + BURST_W'(1);
      else if (r_hs && last_beat && !last_burst)  burst <= burst + BURST_W'(1);
    end
  end

  // Watchdog restarts on any state change or handshake; idle outside a pass.
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst)                                          wd_cnt <= '0;
    else if (!busy || (state_next != state) || any_hs)  wd_cnt <= '0;
    else                                                wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Saturating error count and sticky timeout flag, cleared by an accepted start.
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else if (start_ok) begin
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (wd_expired) timeout_flag <= 1'b1;
      if (((b_hs && b_bad) || (r_hs && r_bad)) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// Randomised AXI slave stub plus scoreboard for the traffic generator.
// Latency: checks start latency, pass completion and a 64-cycle watchdog abort.
// Backpressure: slave readies and R gaps are randomised every cycle.
module tb_ddr3_axi_traffic_gen;

  localparam int          IDW  = 4;
  localparam int          AW   = 32;
  localparam int          DW   = 128;
  localparam int          BL   = 4;
  localparam int          NB   = 2;
  localparam int          TMO  = 64;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_error_count;

  logic awvalid, awready;
  logic [IDW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wlast;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic bvalid, bready;
  logic [IDW-1:0] bid;
  logic [1:0] bresp;
  logic arvalid, arready;
  logic [IDW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid, rready, rlast;
  logic [IDW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;

  always #5 clk = ~clk;

  ddr3_axi_traffic_gen #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL),
    .NUM_BURSTS(NB), .BASE_ADDR(32'h0), .SEED(SEED), .TG_ID(4'h0), .TIMEOUT(TMO)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_error_count(o_error_count),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awid(awid), .m_axi_awaddr(awaddr),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_arid(arid), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rlast(rlast), .m_axi_rresp(rresp)
  );

  int checks = 0;
  int errors = 0;

  // Scenario knobs (written only by the stimulus process).
  int berr_burst = -1;
  int flip_burst = -1;
  int flip_beat  = -1;
  bit hang_ar    = 1'b0;

  // Scoreboard queues filled by the stimulus, drained by the monitor.
  logic [31:0]   exp_aw[$];
  logic [31:0]   exp_ar[$];
  logic [DW-1:0] exp_w[$];

  // Handshake captures (written only by the monitor).
  bit f_aw, f_w, f_b, f_ar, f_r;
  logic [31:0]   c_awaddr, c_araddr;
  logic [DW-1:0] c_wdata;
  int mon_wbeat = 0;

  // Slave memory and progress (written only by the slave stub).
  logic [DW-1:0] mem [int unsigned];
  logic [31:0] wr_addr, rd_addr;
  int wr_beat = 0;
  int rd_beat = 0;
  bit rd_active = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference pattern: address XOR seed, repeated in every 32-bit lane.
  function automatic logic [DW-1:0] model_beat(input logic [31:0] addr);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = addr ^ SEED;
    return d;
  endfunction

  // Monitor: detects handshakes at the falling edge and checks them against the queues.
  initial begin
    forever begin
      @(negedge clk);
      f_aw = awvalid && awready && !rst;
      f_w  = wvalid  && wready  && !rst;
      f_b  = bvalid  && bready  && !rst;
      f_ar = arvalid && arready && !rst;
      f_r  = rvalid  && rready  && !rst;
      if (rst) mon_wbeat = 0;
      if (f_aw) begin
        c_awaddr  = awaddr;
        mon_wbeat = 0;
        chk("aw_expected", exp_aw.size() > 0, 1);
        if (exp_aw.size() > 0) chk("aw_addr", awaddr, exp_aw.pop_front());
        chk("aw_len", awlen, BL - 1);
        chk("aw_size", awsize, 4);
        chk("aw_burst", awburst, 1);
        chk("aw_id", awid, 0);
      end
      if (f_w) begin
        c_wdata = wdata;
        chk("w_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) chk("w_data", wdata, exp_w.pop_front());
        chk("w_strb", wstrb, {(DW/8){1'b1}});
        chk("w_last", wlast, mon_wbeat == BL - 1);
        mon_wbeat = (mon_wbeat + 1) % BL;
      end
      if (f_ar) begin
        c_araddr = araddr;
        chk("ar_expected", exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) chk("ar_addr", araddr, exp_ar.pop_front());
        chk("ar_len", arlen, BL - 1);
        chk("ar_size", arsize, 4);
        chk("ar_burst", arburst, 1);
        chk("ar_id", arid, 0);
      end
    end
  end

  // Slave stub: random readies, stores writes, returns stored data with optional faults.
  initial begin
    logic [31:0] a;
    logic [DW-1:0] d;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0; arready = 0;
    rvalid = 0; rid = '0; rdata = '0; rlast = 0; rresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        rd_active = 0; wr_beat = 0; rd_beat = 0;
      end else begin
        if (f_aw) begin wr_addr = c_awaddr; wr_beat = 0; end
        if (f_b) bvalid = 0;
        if (f_w) begin
          mem[wr_addr + wr_beat * (DW / 8)] = c_wdata;
          wr_beat++;
          if (wr_beat == BL) begin
            bvalid = 1;
            bid    = '0;
            bresp  = (int'(wr_addr / (BL * DW / 8)) == berr_burst) ? 2'b10 : 2'b00;
          end
        end
        if (f_ar) begin rd_addr = c_araddr; rd_beat = 0; rd_active = 1; end
        if (f_r) begin
          rvalid = 0;
          rd_beat++;
          if (rd_beat == BL) rd_active = 0;
        end
        if (rd_active && !rvalid && $urandom_range(0, 2) != 0) begin
          a = rd_addr + rd_beat * (DW / 8);
          d = mem.exists(a) ? mem[a] : '0;
          if (int'(rd_addr / (BL * DW / 8)) == flip_burst && rd_beat == flip_beat) d[0] = ~d[0];
          rdata  = d;
          rlast  = (rd_beat == BL - 1);
          rid    = '0;
          rresp  = 2'b00;
          rvalid = 1;
        end
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        arready = hang_ar ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic setup_expect(input int berr, input int fb, input int fbeat, input bit hang);
    berr_burst = berr; flip_burst = fb; flip_beat = fbeat; hang_ar = hang;
    exp_aw.delete(); exp_ar.delete(); exp_w.delete();
    for (int n = 0; n < NB; n++) begin
      exp_aw.push_back(32'(n * BL * DW / 8));
      if (!hang) exp_ar.push_back(32'(n * BL * DW / 8));
      for (int k = 0; k < BL; k++) exp_w.push_back(model_beat(32'(n * BL * DW / 8 + k * DW / 8)));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("start_awvalid", awvalid, 1);
    chk("start_busy", o_busy, 1);
    chk("start_done_clr", o_done, 0);
    chk("start_err_clr", o_error_count, 0);
    chk("start_timeout_clr", o_timeout, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (o_done) break;
    end
    chk("done_reached", o_done, 1);
  endtask

  task automatic run_pass(input int berr, input int fb, input int fbeat, input bit busy_start);
    int exp_err;
    setup_expect(berr, fb, fbeat, 1'b0);
    exp_err = ((berr >= 0) ? 1 : 0) + ((fb >= 0) ? 1 : 0);
    pulse_start();
    if (busy_start) begin
      repeat (8) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
      chk("ignored_start_busy", o_busy, 1);
    end
    wait_done();
    chk("pass", o_pass, exp_err == 0);
    chk("error_count", o_error_count, exp_err);
    chk("timeout_flag", o_timeout, 0);
    chk("busy_at_done", o_busy, 0);
    chk("valids_at_done", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    chk("ar_left", exp_ar.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valids"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk({tag, "_status"}, {o_busy, o_done, o_pass, o_timeout}, 0);
    chk({tag, "_errcnt"}, o_error_count, 0);
    chk({tag, "_addr"}, {awaddr, araddr}, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wlast"}, wlast, 0);
  endtask

  // Stimulus: scenario sequence.
  initial begin
    logic [DW-1:0] lit;
    int n;
    bit found;

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 0;

    // Basic pass with an ignored start while busy.
    run_pass(-1, -1, -1, 1'b1);
    lit = {4{32'hA5A5_0010}};
    chk("mem_beat_0x10", mem.exists(32'h10) ? mem[32'h10] : '0, lit);

    // Read-data corruption on burst 1 beat 2 (start from DONE).
    run_pass(-1, 1, 2, 1'b0);
    // Error write response on burst 0.
    run_pass(0, -1, -1, 1'b0);
    // Clean pass after errors: counters must have been cleared.
    run_pass(-1, -1, -1, 1'b0);

    // Hung slave: AR never accepted.
    setup_expect(-1, -1, -1, 1'b1);
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (arvalid) begin found = 1; break; end
    end
    chk("hang_arvalid_seen", found, 1);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      n++;
      if (o_done) break;
    end
    chk("hang_timeout_window", (n >= TMO - 1) && (n <= TMO + 1), 1);
    chk("hang_done", o_done, 1);
    chk("hang_timeout", o_timeout, 1);
    chk("hang_pass", o_pass, 0);
    chk("hang_arvalid_drop", arvalid, 0);
    chk("hang_errcnt", o_error_count, 0);

    // Restart from a timed-out DONE with a healthy slave.
    run_pass(-1, -1, -1, 1'b0);

    // Asynchronous reset during W beat 2.
    setup_expect(-1, -1, -1, 1'b0);
    pulse_start();
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (wvalid && wr_beat == 2) begin found = 1; break; end
    end
    chk("reached_w_beat2", found, 1);
    rst = 1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run_pass(-1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
